key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Input-conditioning stage that sits directly upstream of the LED/HEX display logic on DE-series boards. It takes the raw, active-low, bouncing KEY pushbuttons, synchronizes them to CLOCK_50 and debounces them. It outputs a clean active-high level per key, plus single-cycle press, release and auto-repeat pulses. The display/counter logic uses these pulses as its step/enable inputs.

Parameters:
N_KEYS, 2, number of pushbuttons handled (independent channel per key)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (20 ms at 50 MHz); must be >= 1
HOLD_CYCLES, 25000000, cycles a key must stay pressed before the first auto-repeat pulse (0.5 s); must be >= 1
REPEAT_CYCLES, 5000000, cycles between subsequent auto-repeat pulses (0.1 s); must be >= 1

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge
Resetn  input  1  asynchronous, active-low reset
KEY  input  N_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50
KEY_LEVEL  output  N_KEYS  debounced state, active-high (1 = pressed)
KEY_PRESS  output  N_KEYS  1-cycle pulse on accepted press
KEY_RELEASE  output  N_KEYS  1-cycle pulse on accepted release
KEY_RPT  output  N_KEYS  1-cycle auto-repeat pulse while held

Behaviour:
- One clock: CLOCK_50. Reset is asynchronous and active-low (Resetn).
- Reset, including assertion mid-operation:
  - Sync flops = 1 (released).
  - All counters = 0.
  - KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_RPT = 0.
  - Every channel FSM goes to IDLE.
- All outputs are registered. Channels are fully independent; simultaneous events on different keys are all reported in the same cycle.
- Synchronizer: 2 flops per key. raw[i] = ~sync2[i].
- Debounce counter (width clog2(DEBOUNCE_CYCLES)+1), per key:
  - If raw == KEY_LEVEL, dcnt <= 0.
  - Otherwise dcnt increments each cycle.
  - When dcnt == DEBOUNCE_CYCLES-1 and raw still differs: KEY_LEVEL <= raw, dcnt <= 0.
  - Any single cycle where raw matches KEY_LEVEL restarts the count, so glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Latency: if KEY[i] changes before edge 0 and then stays stable, KEY_LEVEL[i] changes at edge DEBOUNCE_CYCLES+2.
- KEY_PRESS / KEY_RELEASE:
  - Asserted on the same edge KEY_LEVEL goes 0->1 / 1->0.
  - Cleared on the next edge.
  - Never asserted together on the same key.
- Per-key FSM:
  - IDLE (KEY_LEVEL = 0): on accepted press -> HELD, hcnt <= 0.
  - HELD: hcnt increments each cycle. When hcnt == HOLD_CYCLES-1: KEY_RPT pulse, hcnt <= 0, -> REPEATING. First KEY_RPT therefore occurs HOLD_CYCLES edges after the KEY_PRESS edge.
  - REPEATING: hcnt increments. When hcnt == REPEAT_CYCLES-1: KEY_RPT pulse, hcnt <= 0. Pulses are spaced exactly REPEAT_CYCLES cycles apart.
  - HELD/REPEATING: on accepted release -> IDLE, hcnt <= 0. KEY_RPT is suppressed from that edge on. If release and a repeat terminal count land on the same edge, release wins (no KEY_RPT).
- KEY_PRESS never coincides with KEY_RPT. KEY_RPT is only high in HELD/REPEATING.
- hcnt width = clog2(max(HOLD_CYCLES, REPEAT_CYCLES))+1. Counters never wrap because they are cleared at terminal count.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_KEYS=2.

- Reset: hold Resetn=0 with KEY=2'b00 -> all outputs 0. Release reset, KEY=2'b11 -> outputs stay 0 indefinitely.
- Clean press: KEY[0] low before edge 0 and held -> KEY_LEVEL[0]=1 from edge 6; KEY_PRESS[0]=1 only for the cycle after edge 6; KEY[1] channel unaffected.
- Bounce rejection: KEY[0] low for 3 cycles, high for 1, repeated 5 times -> KEY_LEVEL[0] stays 0, no pulses. Then held low -> accepted 6 edges after the final fall.
- Auto-repeat: press accepted at edge E, held -> KEY_RPT[0] pulses at E+10, E+13, E+16, ...; KEY_PRESS only at E.
- Release during repeat: release KEY[0] so the release is accepted at edge R, coinciding with a repeat terminal count -> KEY_RELEASE[0] at R, no KEY_RPT at R or later, KEY_LEVEL[0]=0 from R.
- Simultaneous/async reset: both keys pressed on the same cycle -> KEY_PRESS=2'b11 in one cycle. Assert Resetn=0 mid-HELD, asynchronously to CLOCK_50 -> outputs 0 immediately. After deassertion with keys still held, a new press is accepted DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/key_debounce_if.sv
// Pushbutton bundle between the board pins and the display logic: raw
// active-low keys in, debounced level and event pulses out.
interface key_debounce_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] KEY_LEVEL;
  logic [N_KEYS-1:0] KEY_PRESS;
  logic [N_KEYS-1:0] KEY_RELEASE;
  logic [N_KEYS-1:0] KEY_RPT;

  // Board/stimulus side drives the raw keys and consumes the conditioned outputs.
  modport master (
    output KEY,
    input  KEY_LEVEL,
    input  KEY_PRESS,
    input  KEY_RELEASE,
    input  KEY_RPT
  );

  // Debouncer side.
  modport slave (
    input  KEY,
    output KEY_LEVEL,
    output KEY_PRESS,
    output KEY_RELEASE,
    output KEY_RPT
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer, debouncer and press/release/auto-repeat pulse generator
// for active-low DE-series pushbuttons; every output is registered.
module key_debounce #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input logic         CLOCK_50,
  input logic         Resetn,
  key_debounce_if.slave kif
);

  localparam int DCNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HCNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W   = $clog2(HCNT_MAX) + 1;

  localparam logic [DCNT_W-1:0] D_TERM = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] H_TERM = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [HCNT_W-1:0] R_TERM = HCNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic [N_KEYS-1:0] level_vec;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] rel_vec;
  logic [N_KEYS-1:0] rpt_vec;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic              sync1;
    logic              sync2;
    logic              raw;
    logic              differ;
    logic              accept;
    logic              press_evt;
    logic              release_evt;
    logic [DCNT_W-1:0] dcnt;
    logic              level;
    logic              press_q;
    logic              rel_q;

    state_t            state;
    state_t            state_next;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_next;
    logic              rpt_q;
    logic              rpt_next;

    assign raw         = ~sync2;
    assign differ      = raw ^ level;
    assign accept      = differ && (dcnt == D_TERM);
    assign press_evt   = accept &&  raw;
    assign release_evt = accept && !raw;

    // Synchronizer and debounce counter. Sync flops reset to 1 so a key held
    // through reset is seen as a fresh press once reset is released.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        dcnt    <= '0;
        level   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1   <= kif.KEY[i];
        sync2   <= sync1;
        press_q <= press_evt;
        rel_q   <= release_evt;
        if (!differ) begin
          dcnt <= '0;
        end else if (accept) begin
          level <= raw;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + DCNT_W'(1);
        end
      end
    end

    // Hold/repeat FSM: state register (KEY_RPT is registered alongside).
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
        state <= IDLE;
        hcnt  <= '0;
        rpt_q <= 1'b0;
      end else begin
        state <= state_next;
        hcnt  <= hcnt_next;
        rpt_q <= rpt_next;
      end
    end

    // Next-state logic; release always takes priority over a terminal count.
    // NOTE: defaults at the top of the comb block keep it free of inferred latches.
    always_comb begin
      state_next = state;
      hcnt_next  = hcnt;
      case (state)
        IDLE: begin
          if (press_evt) begin
            state_next = HELD;
            hcnt_next  = '0;
          end
        end
        HELD: begin
          if (release_evt) begin
            state_next = IDLE;
            hcnt_next  = '0;
          end else if (hcnt == H_TERM) begin
            state_next = REPEATING;
            hcnt_next  = '0;
          end else begin
            hcnt_next = hcnt + HCNT_W'(1);
          end
        end
        REPEATING: begin
          if (release_evt) begin
            state_next = IDLE;
            hcnt_next  = '0;
          end else if (hcnt == R_TERM) begin
            hcnt_next = '0;
          end else begin
            hcnt_next = hcnt + HCNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          hcnt_next  = '0;
        end
      endcase
    end

    // Output logic: one repeat pulse per terminal count while still held.
    always_comb begin
      rpt_next = 1'b0;
      case (state)
        HELD:      rpt_next = !release_evt && (hcnt == H_TERM);
        REPEATING: rpt_next = !release_evt && (hcnt == R_TERM);
        default:   rpt_next = 1'b0;
      endcase
    end

    assign level_vec[i] = level;
    assign press_vec[i] = press_q;
    assign rel_vec[i]   = rel_q;
    assign rpt_vec[i]   = rpt_q;
  end

  assign kif.KEY_LEVEL   = level_vec;
  assign kif.KEY_PRESS   = press_vec;
  assign kif.KEY_RELEASE = rel_vec;
  assign kif.KEY_RPT     = rpt_vec;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE=4, HOLD=10, REPEAT=3. Edge k of a
// scenario is the k-th rising edge after the one just before KEY was changed.
module tb_key_debounce;
  localparam int N_KEYS = 2;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 3;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_debounce_if #(.N_KEYS(N_KEYS)) kif ();

  key_debounce #(
    .N_KEYS         (N_KEYS),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .kif     (kif.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                            input logic [1:0] rel, input logic [1:0] rpt);
    logic [7:0] obs;
    logic [7:0] want;
    obs  = {kif.KEY_LEVEL, kif.KEY_PRESS, kif.KEY_RELEASE, kif.KEY_RPT};
    want = {lvl, prs, rel, rpt};
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed lvl/prs/rel/rpt=%b expected %b", tag, obs, want);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rpt;

    // Reset held with both keys pressed: everything stays 0.
    kif.KEY = 2'b00;
    #2 Resetn = 1'b0;
    #1 expect_out("reset_async", 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (3) begin
      step();
      expect_out("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    kif.KEY = 2'b11;
    Resetn  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out($sformatf("idle k=%0d", k), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Clean press of key 0, auto-repeat at 16,19,22,25; release driven after
    // edge 22 is accepted at edge 28, which is also a repeat terminal count.
    kif.KEY = 2'b10;
    for (int k = 1; k <= 35; k++) begin
      step();
      lvl = (k >= 6 && k < 28) ? 2'b01 : 2'b00;
      prs = (k == 6) ? 2'b01 : 2'b00;
      rel = (k == 28) ? 2'b01 : 2'b00;
      rpt = (k >= 16 && k < 28 && ((k - 16) % 3) == 0) ? 2'b01 : 2'b00;
      expect_out($sformatf("press_repeat k=%0d", k), lvl, prs, rel, rpt);
      if (k == 22) kif.KEY = 2'b11;
    end

    // Bounce: 3 cycles low, 1 high, five times -> never accepted.
    for (int p = 0; p < 5; p++) begin
      kif.KEY = 2'b10;
      repeat (3) begin
        step();
        expect_out($sformatf("bounce_low p=%0d", p), 2'b00, 2'b00, 2'b00, 2'b00);
      end
      kif.KEY = 2'b11;
      step();
      expect_out($sformatf("bounce_high p=%0d", p), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Final fall accepted 6 edges later; short hold then release.
    kif.KEY = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      step();
      lvl = (k >= 6 && k < 12) ? 2'b01 : 2'b00;
      prs = (k == 6) ? 2'b01 : 2'b00;
      rel = (k == 12) ? 2'b01 : 2'b00;
      expect_out($sformatf("after_bounce k=%0d", k), lvl, prs, rel, 2'b00);
      if (k == 6) kif.KEY = 2'b11;
    end
    repeat (3) begin
      step();
      expect_out("quiet", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Both keys pressed on the same cycle.
    kif.KEY = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      lvl = (k >= 6) ? 2'b11 : 2'b00;
      prs = (k == 6) ? 2'b11 : 2'b00;
      expect_out($sformatf("dual_press k=%0d", k), lvl, prs, 2'b00, 2'b00);
    end

    // Asynchronous reset mid-HELD, away from any clock edge.
    #3 Resetn = 1'b0;
    #1 expect_out("async_reset_now", 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) begin
      step();
      expect_out("async_reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Keys still held: new press accepted 6 edges after reset release.
    Resetn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      lvl = (k >= 6) ? 2'b11 : 2'b00;
      prs = (k == 6) ? 2'b11 : 2'b00;
      expect_out($sformatf("post_reset k=%0d", k), lvl, prs, 2'b00, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
